wb_stage: RTL and testbench

- Write-side driver for the 32-entry register file.
- Takes the MEM-stage result bundle and registers it as the MEM/WB pipeline register.
- Performs load-data lane extraction and sign/zero extension, then selects the writeback source.
- Drives the register file write port (RegWrite, rd, write_data) and the WB forwarding path.
- Also keeps a retired-instruction counter for the CSR block.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/load_extend.sv | 33 +++
 rtl/wb_stage.sv | 101 ++++++++++
 tb/tb_wb_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings: writeback source selects and load funct3 codes.
package riscv_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned WB_SEL_W  = 2;
    localparam int unsigned FUNCT3_W  = 3;

    localparam logic [WB_SEL_W-1:0] WB_ALU  = 2'd0;
    localparam logic [WB_SEL_W-1:0] WB_LOAD = 2'd1;
    localparam logic [WB_SEL_W-1:0] WB_PC4  = 2'd2;
    localparam logic [WB_SEL_W-1:0] WB_IMM  = 2'd3;

    localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load lane extraction and sign/zero extension of an aligned data-memory word.
module load_extend
    import riscv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [2:0]   funct3,
    input  logic [1:0]   addr_lo,
    input  logic [N-1:0] rdata,
    output logic [N-1:0] ext_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        // Halfword lane only depends on addr_lo[1]; the low offset bit is ignored.
        half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
    end

    always_comb begin
        ext_data = rdata;
        case (funct3)
            F3_LB:   ext_data = {{(N-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  ext_data = {{(N-8){1'b0}}, byte_lane};
            F3_LH:   ext_data = {{(N-16){half_lane[15]}}, half_lane};
            F3_LHU:  ext_data = {{(N-16){1'b0}}, half_lane};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register driving the register-file write port, plus the retired-instruction counter.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [1:0]       mem_addr_lo,
    input  logic [N-1:0]     mem_alu_result,
    input  logic [N-1:0]     mem_rdata,
    input  logic [N-1:0]     mem_pc_plus4,
    input  logic [N-1:0]     mem_imm,
    input  logic             stall,
    input  logic             flush,
    output logic             RegWrite,
    output logic [4:0]       rd,
    output logic [N-1:0]     write_data,
    output logic             wb_valid,
    output logic [CNT_W-1:0] instret
);

    logic             wb_valid_q,   wb_valid_d;
    logic             reg_write_q,  reg_write_d;
    logic [4:0]       rd_q,         rd_d;
    logic [N-1:0]     wdata_q,      wdata_d;
    logic [CNT_W-1:0] instret_q,    instret_d;

    logic [N-1:0]     load_data;
    logic [N-1:0]     sel_data;

    load_extend #(.N(N)) u_load_extend (
        .funct3   (mem_funct3),
        .addr_lo  (mem_addr_lo),
        .rdata    (mem_rdata),
        .ext_data (load_data)
    );

    // Writeback source mux.
    always_comb begin
        sel_data = mem_alu_result;
        case (mem_wb_sel)
            WB_ALU:  sel_data = mem_alu_result;
            WB_LOAD: sel_data = load_data;
            WB_PC4:  sel_data = mem_pc_plus4;
            default: sel_data = mem_imm;
        endcase
    end

    // Next-state: flush beats stall; stall holds everything including the counter.
    always_comb begin
        wb_valid_d  = wb_valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        instret_d   = instret_q;
        if (flush) begin
            wb_valid_d  = 1'b0;
            reg_write_d = 1'b0;
            rd_d        = 5'd0;
            wdata_d     = '0;
        end else if (!stall) begin
            wb_valid_d  = mem_valid;
            reg_write_d = mem_valid & mem_reg_write & (mem_rd != 5'd0);
            rd_d        = mem_rd;
            wdata_d     = sel_data;
            if (mem_valid) begin
                instret_d = instret_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            wdata_q     <= '0;
            instret_q   <= '0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            instret_q   <= instret_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign RegWrite   = reg_write_q;
    assign rd         = rd_q;
    assign write_data = wdata_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; a second CNT_W=4 instance checks counter wrap.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_reg_write = 1'b0;
    logic [4:0]  mem_rd = 5'd0;
    logic [1:0]  mem_wb_sel = 2'd0;
    logic [2:0]  mem_funct3 = 3'd0;
    logic [1:0]  mem_addr_lo = 2'd0;
    logic [31:0] mem_alu_result = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] mem_pc_plus4 = 32'd0;
    logic [31:0] mem_imm = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        RegWrite, RegWrite4;
    logic [4:0]  rd, rd4;
    logic [31:0] write_data, write_data4;
    logic        wb_valid, wb_valid4;
    logic [63:0] instret;
    logic [3:0]  instret4;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_cnt = 64'd0;

    always #5 clk = ~clk;

    wb_stage #(.N(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
        .mem_addr_lo(mem_addr_lo), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm), .stall(stall), .flush(flush),
        .RegWrite(RegWrite), .rd(rd), .write_data(write_data), .wb_valid(wb_valid),
        .instret(instret)
    );

    wb_stage #(.N(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
        .mem_addr_lo(mem_addr_lo), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm), .stall(stall), .flush(flush),
        .RegWrite(RegWrite4), .rd(rd4), .write_data(write_data4), .wb_valid(wb_valid4),
        .instret(instret4)
    );

    // Advance one clock; the expected retire count follows rst > flush > stall > valid.
    task automatic step();
        if (rst) exp_cnt = 64'd0;
        else if (!flush && !stall && mem_valid) exp_cnt = exp_cnt + 64'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd5;
        mem_wb_sel = 2'd0; mem_alu_result = 32'h11;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({RegWrite, rd, write_data, wb_valid, instret} !== 71'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: RegWrite=%b rd=%0d wdata=%h valid=%b instret=%0d, want all 0",
                         i, RegWrite, rd, write_data, wb_valid, instret);
            end
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (RegWrite !== 1'b1 || rd !== 5'd5 || write_data !== 32'h11) begin
            n_fail++;
            $display("FAIL reset_release: RegWrite=%b rd=%0d wdata=%h, want 1/5/00000011", RegWrite, rd, write_data);
        end
        n_tests++;
        if (instret !== 64'd1) begin
            n_fail++;
            $display("FAIL reset_instret: got %0d want 1", instret);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  off [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        logic [31:0] exp [5] = '{32'hFFFFFFA5, 32'h000000F0, 32'hFFFF8070, 32'h00008070, 32'h8070F0A5};
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd10;
        mem_wb_sel = 2'd1; mem_rdata = 32'h8070F0A5; mem_alu_result = 32'hDEAD0000;
        for (int i = 0; i < 5; i++) begin
            mem_funct3 = f3[i]; mem_addr_lo = off[i];
            step();
            n_tests++;
            if (write_data !== exp[i]) begin
                n_fail++;
                $display("FAIL load_ext f3=%b off=%0d: got %h want %h", f3[i], off[i], write_data, exp[i]);
            end
        end
    endtask

    task automatic test_src_select();
        logic [1:0]  sel [3] = '{2'd0, 2'd2, 2'd3};
        logic [31:0] exp [3] = '{32'h00000011, 32'h00000104, 32'hABCDE000};
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd12; mem_funct3 = 3'b000;
        mem_alu_result = 32'h11; mem_pc_plus4 = 32'h104; mem_imm = 32'hABCDE000;
        mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            mem_wb_sel = sel[i];
            step();
            n_tests++;
            if (write_data !== exp[i] || RegWrite !== 1'b1 || rd !== 5'd12) begin
                n_fail++;
                $display("FAIL src_sel%0d: wdata=%h RegWrite=%b rd=%0d, want %h/1/12",
                         sel[i], write_data, RegWrite, rd, exp[i]);
            end
        end
    endtask

    task automatic test_x0_and_invalid();
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd0; mem_wb_sel = 2'd0;
        step();
        n_tests++;
        if (RegWrite !== 1'b0 || wb_valid !== 1'b1 || instret !== exp_cnt) begin
            n_fail++;
            $display("FAIL x0_guard: RegWrite=%b valid=%b instret=%0d, want 0/1/%0d",
                     RegWrite, wb_valid, instret, exp_cnt);
        end
        mem_valid = 1'b0; mem_rd = 5'd3;
        step();
        n_tests++;
        if (RegWrite !== 1'b0 || wb_valid !== 1'b0 || instret !== exp_cnt) begin
            n_fail++;
            $display("FAIL invalid: RegWrite=%b valid=%b instret=%0d, want 0/0/%0d",
                     RegWrite, wb_valid, instret, exp_cnt);
        end
    endtask

    task automatic test_stall_flush();
        logic [63:0] held;
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd7; mem_wb_sel = 2'd0;
        mem_alu_result = 32'h55;
        step();
        held = exp_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rd = 5'(9 + i); mem_alu_result = 32'h99 + 32'(i); mem_valid = 1'(i & 1) | 1'b1;
            step();
            n_tests++;
            if (write_data !== 32'h55 || rd !== 5'd7 || RegWrite !== 1'b1 || wb_valid !== 1'b1
                || instret !== held) begin
                n_fail++;
                $display("FAIL stall_hold%0d: wdata=%h rd=%0d RegWrite=%b valid=%b instret=%0d, want 55/7/1/1/%0d",
                         i, write_data, rd, RegWrite, wb_valid, instret, held);
            end
        end
        flush = 1'b1;
        step();
        n_tests++;
        if (RegWrite !== 1'b0 || wb_valid !== 1'b0 || rd !== 5'd0 || write_data !== 32'd0
            || instret !== held) begin
            n_fail++;
            $display("FAIL stall_flush: RegWrite=%b valid=%b rd=%0d wdata=%h instret=%0d, want 0/0/0/0/%0d",
                     RegWrite, wb_valid, rd, write_data, instret, held);
        end
        flush = 1'b0;
        step();
        n_tests++;
        if (write_data !== 32'd0 || instret !== held) begin
            n_fail++;
            $display("FAIL post_flush_stall: wdata=%h instret=%0d, want 0/%0d", write_data, instret, held);
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd4; mem_alu_result = 32'h44;
        step();
        stall = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_tests++;
        if ({RegWrite, rd, write_data, wb_valid, instret} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: RegWrite=%b rd=%0d wdata=%h valid=%b instret=%0d, want all 0",
                     RegWrite, rd, write_data, wb_valid, instret);
        end
        stall = 1'b0;
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0; mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd1;
        for (int i = 0; i < 17; i++) step();
        n_tests++;
        if (instret4 !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_cnt4: got %0d want 1", instret4);
        end
        n_tests++;
        if (instret !== 64'd17) begin
            n_fail++;
            $display("FAIL wrap_cnt64: got %0d want 17", instret);
        end
    endtask

    initial begin
        test_reset();
        test_load_extend();
        test_src_select();
        test_x0_and_invalid();
        test_stall_flush();
        test_reset_mid_stall();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
